// File: rtl/ifetch_pkg.sv
// Shared constants for the byte-wise instruction fetch sequencer: FSM encodings,
// instruction geometry and the NOP substituted for misaligned fetches.
package ifetch_pkg;

    localparam int          BYTES_PER_INSTR = 4;
    localparam logic [31:0] NOP_INSTR       = 32'h00000013;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_LAST  = 2'd2;
    localparam state_t ST_VALID = 2'd3;

endpackage

// File: rtl/ifetch_assembler.sv
// Collects the low three ROM bytes into lanes, then commits them with the final byte
// (or a NOP) to the instruction register, which holds its value until the next commit.
module ifetch_assembler
    import ifetch_pkg::*;
#(
    parameter int READ_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clear_i,
    input  logic                  cap_en_i,
    input  logic [1:0]            lane_i,
    input  logic                  load_i,
    input  logic                  load_nop_i,
    input  logic [READ_WIDTH-1:0] rdata_i,
    output logic [DATA_WIDTH-1:0] instr_o
);

    localparam int LANE_BITS = READ_WIDTH * (BYTES_PER_INSTR - 1);

    logic [LANE_BITS-1:0]  lanes_q, lanes_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;

    always_comb begin
        lanes_d = lanes_q;
        instr_d = instr_q;
        if (clear_i) begin
            lanes_d = '0;
        end else if (cap_en_i) begin
            for (int l = 0; l < BYTES_PER_INSTR - 1; l++) begin
                if (lane_i == 2'(l)) lanes_d[l*READ_WIDTH +: READ_WIDTH] = rdata_i;
            end
        end
        // The top byte is never stored in a lane: it goes straight into the commit.
        if (load_nop_i)  instr_d = DATA_WIDTH'(NOP_INSTR);
        else if (load_i) instr_d = {rdata_i, lanes_q};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lanes_q <= '0;
            instr_q <= '0;
        end else begin
            lanes_q <= lanes_d;
            instr_q <= instr_d;
        end
    end

    assign instr_o = instr_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: four byte reads from a 1-cycle ROM per request, little-endian assembly.
// IFETCH_ALIGN_CHECK_EN adds the misalign port and returns a NOP for unaligned requests.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int READ_WIDTH     = 8,
    parameter int MEM_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [ADDRESS_WIDTH-1:0]  req_addr_i,
    input  logic                      flush_i,
    output logic                      mem_en_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [READ_WIDTH-1:0]     mem_rdata_i,
    output logic                      instr_valid_o,
    input  logic                      instr_ready_i,
    output logic [DATA_WIDTH-1:0]     instr_o,
`ifdef IFETCH_ALIGN_CHECK_EN
    output logic                      misalign_o,
`endif
    output logic [ADDRESS_WIDTH-1:0]  instr_addr_o
);

    localparam int KW = $clog2(BYTES_PER_INSTR);

    state_t                   state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [ADDRESS_WIDTH-1:0] base_q, base_d;
    logic                     accept, handshake, mis_req;

    assign req_ready_o = !flush_i && (state_q == ST_IDLE ||
                                      (state_q == ST_VALID && instr_ready_i));
    assign accept      = req_valid_i && req_ready_o;
    assign handshake   = state_q == ST_VALID && instr_ready_i;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    assign mis_req = accept && (req_addr_i[1:0] != 2'b00);

    always_comb begin
        misalign_d = misalign_q;
        if (accept)                    misalign_d = mis_req;
        else if (handshake || flush_i) misalign_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) misalign_q <= 1'b0;
        else          misalign_q <= misalign_d;
    end

    assign misalign_o = misalign_q;
`else
    assign mis_req = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        case (state_q)
            ST_READ: begin
                k_d = k_q + 1'b1;
                if (k_q == KW'(BYTES_PER_INSTR - 1)) state_d = ST_LAST;
            end
            ST_LAST:  state_d = ST_VALID;
            ST_VALID: if (handshake) state_d = ST_IDLE;
            default:  state_d = state_q;
        endcase
        if (accept) begin
            base_d  = req_addr_i;
            k_d     = '0;
            state_d = mis_req ? ST_VALID : ST_READ;
        end
        if (flush_i) begin
            state_d = ST_IDLE;
            k_d     = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
        end
    end

    // Address arithmetic stays in the ROM's width so the byte sequence wraps at the top.
    assign mem_en_o      = state_q == ST_READ;
    assign mem_addr_o    = mem_en_o ? base_q[MEM_ADDR_WIDTH-1:0] + MEM_ADDR_WIDTH'(k_q) : '0;
    assign instr_valid_o = state_q == ST_VALID;
    assign instr_addr_o  = base_q;

    // Byte issued at k arrives one cycle later, so READ at k captures lane k-1.
    ifetch_assembler #(
        .READ_WIDTH (READ_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_asm (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clear_i    (flush_i || accept),
        .cap_en_i   (state_q == ST_READ && k_q != '0 && !flush_i),
        .lane_i     (2'(k_q - 1'b1)),
        .load_i     (state_q == ST_LAST && !flush_i),
        .load_nop_i (mis_req),
        .rdata_i    (mem_rdata_i),
        .instr_o    (instr_o)
    );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a 32-byte synchronous ROM model.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        mem_en;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_addr;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_total  = 0;
    int n_passed = 0;

    logic [7:0] rom [32];

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_en) mem_rdata <= rom[mem_addr];

    ifetch_ctrl dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .flush_i       (flush),
        .mem_en_o      (mem_en),
        .mem_addr_o    (mem_addr),
        .mem_rdata_i   (mem_rdata),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
`ifdef IFETCH_ALIGN_CHECK_EN
        .misalign_o    (misalign),
`endif
        .instr_addr_o  (instr_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        logic [4:0] wrap_seq [4];
        wrap_seq[0] = 5'h1E; wrap_seq[1] = 5'h1F; wrap_seq[2] = 5'h00; wrap_seq[3] = 5'h01;

        for (int i = 0; i < 32; i++) rom[i] = 8'(8'hC0 + i);
        rom[0] = 8'h93; rom[1] = 8'h00; rom[2] = 8'h50; rom[3] = 8'h00;
        rom[4] = 8'h13; rom[5] = 8'h01; rom[6] = 8'hA0; rom[7] = 8'h00;
        rom[30] = 8'hAA; rom[31] = 8'hBB;
        mem_rdata = 8'h00;

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0; instr_ready = 1'b0;
        #12;
        chk("rst_req_ready",   64'(req_ready),   64'd1);
        chk("rst_mem_en",      64'(mem_en),      64'd0);
        chk("rst_mem_addr",    64'(mem_addr),    64'd0);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr",       64'(instr),       64'd0);
        chk("rst_instr_addr",  64'(instr_addr),  64'd0);
        rst_n = 1'b1;

        // Basic fetch from address 0
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("basic_mem_en",   64'(mem_en),      64'd1);
            chk("basic_mem_addr", 64'(mem_addr),    64'(i));
            chk("basic_no_valid", 64'(instr_valid), 64'd0);
            tick();
        end
        chk("basic_last_mem_en", 64'(mem_en),      64'd0);
        chk("basic_last_valid",  64'(instr_valid), 64'd0);
        tick();
        chk("basic_valid",      64'(instr_valid), 64'd1);
        chk("basic_instr",      64'(instr),       64'h00500093);
        chk("basic_instr_addr", 64'(instr_addr),  64'h0);

        // Backpressure for three cycles, then back-to-back accept at address 4
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_ready", 64'(req_ready),   64'd0);
            chk("bp_valid",     64'(instr_valid), 64'd1);
            chk("bp_instr",     64'(instr),       64'h00500093);
            tick();
        end
        req_valid = 1'b1; req_addr = 32'h4; instr_ready = 1'b1;
        #1;
        chk("b2b_req_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0; instr_ready = 1'b0;
        chk("b2b_valid_drop", 64'(instr_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_mem_addr", 64'(mem_addr), 64'(4 + i));
            tick();
        end
        tick();
        chk("b2b_valid",      64'(instr_valid), 64'd1);
        chk("b2b_instr",      64'(instr),       64'h00A00113);
        chk("b2b_instr_addr", 64'(instr_addr),  64'h4);
        instr_ready = 1'b1;
        tick();
        chk("b2b_idle_valid", 64'(instr_valid), 64'd0);
        chk("b2b_instr_hold", 64'(instr),       64'h00A00113);

`ifndef IFETCH_ALIGN_CHECK_EN
        // ROM address wraps and upper request bits are ignored
        req_valid = 1'b1; req_addr = 32'h3E;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wrap_mem_addr", 64'(mem_addr), 64'(wrap_seq[i]));
            tick();
        end
        tick();
        chk("wrap_valid",      64'(instr_valid), 64'd1);
        chk("wrap_instr",      64'(instr),       64'h0093BBAA);
        chk("wrap_instr_addr", 64'(instr_addr),  64'h3E);
        tick();
`endif

        // Flush in READ k=2 while a request is offered
        req_valid = 1'b1; req_addr = 32'h8;
        tick();
        tick();
        tick();
        chk("flush_k2_addr", 64'(mem_addr), 64'h0A);
        flush = 1'b1;
        #1;
        chk("flush_req_ready", 64'(req_ready), 64'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_idle_mem_en", 64'(mem_en), 64'd0);
        for (int i = 0; i < 6; i++) begin
            chk("flush_no_valid", 64'(instr_valid), 64'd0);
            chk("flush_no_mem",   64'(mem_en),      64'd0);
            tick();
        end
        req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("post_flush_valid",      64'(instr_valid), 64'd1);
        chk("post_flush_instr",      64'(instr),       64'hCBCAC9C8);
        chk("post_flush_instr_addr", 64'(instr_addr),  64'h8);
        tick();

        // Asynchronous reset mid-fetch at k=2
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("rst_mid_mem_en_before", 64'(mem_en), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_en",      64'(mem_en),      64'd0);
        chk("rst_mid_mem_addr",    64'(mem_addr),    64'd0);
        chk("rst_mid_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_mid_instr",       64'(instr),       64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
        tick();
        chk("rst_mid_no_residual", 64'(mem_en), 64'd0);

`ifdef IFETCH_ALIGN_CHECK_EN
        // Misaligned request returns a NOP without touching the ROM
        req_valid = 1'b1; req_addr = 32'h2;
        chk("mis_accept_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        chk("mis_valid",      64'(instr_valid), 64'd1);
        chk("mis_instr",      64'(instr),       64'h00000013);
        chk("mis_flag",       64'(misalign),    64'd1);
        chk("mis_mem_en",     64'(mem_en),      64'd0);
        chk("mis_instr_addr", 64'(instr_addr),  64'h2);
        tick();
        chk("mis_clear_flag",  64'(misalign),    64'd0);
        chk("mis_clear_valid", 64'(instr_valid), 64'd0);
        chk("mis_mem_en_end",  64'(mem_en),      64'd0);
`endif

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch sequencer for the byte-wide instruction ROM. Accepts a fetch address from the core, issues four consecutive byte reads to a synchronous 1-cycle-latency byte memory, assembles them little-endian into a 32-bit instruction and presents it to the decoder over a valid/ready handshake. It sits between the PC register and the decode stage and owns every ROM access, including redirect flushes.

## Interface
- ADDRESS_WIDTH, 32, width of fetch/PC address
- DATA_WIDTH, 32, assembled instruction width (fixed 4 × READ_WIDTH)
- READ_WIDTH, 8, memory read port width
- MEM_ADDR_WIDTH, 5, physical ROM address width (2^5 bytes)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request offered
- req_ready  out  1  request accepted this edge when both high
- req_addr  in  ADDRESS_WIDTH  byte address of instruction
- flush  in  1  synchronous redirect: abort current fetch
- mem_en  out  1  memory read strobe
- mem_addr  out  MEM_ADDR_WIDTH  byte address to ROM
- mem_rdata  in  READ_WIDTH  byte returned one cycle after mem_en
- instr_valid  out  1  instr holds a complete instruction
- instr_ready  in  1  decoder consumes instr
- instr  out  DATA_WIDTH  {b3,b2,b1,b0}, b0 from lowest address
- instr_addr  out  ADDRESS_WIDTH  full req_addr of instr
- misalign  out  1  only with IFETCH_ALIGN_CHECK_EN

## Operation
- States: IDLE, READ (byte counter k = 0..3), LAST, VALID.
- req_ready = !flush && (IDLE || (VALID && instr_ready)).
- Accept: latch req_addr into base/instr_addr, k←0, → READ.
- READ: mem_en=1, mem_addr = base[MEM_ADDR_WIDTH-1:0] + k, modulo 2^MEM_ADDR_WIDTH (wraps, upper address bits ignored); k increments; after k=3 → LAST.
- Byte issued in cycle n is captured from mem_rdata at the end of cycle n+1 into byte lane k.
- LAST: mem_en=0, capture b3 → VALID.
- VALID: instr_valid=1; instr, instr_addr stable until handshake. On instr_valid&&instr_ready: → READ if new request accepted same edge, else → IDLE.
- flush (highest priority): any state → IDLE next edge, partial bytes discarded, instr_valid low next cycle, no request accepted that cycle.
- instr/instr_addr keep last value outside VALID; only instr_valid qualifies them.

## Timing
- Reset values: state IDLE, req_ready=1 (when flush low), mem_en=0, mem_addr=0, instr_valid=0, instr=0, instr_addr=0, misalign=0.
- Request accepted at edge E0 → mem_en high cycles 1–4 → instr_valid high from cycle 6 (after E5): 5-edge latency, throughput one instruction per 5 cycles with back-to-back requests.
- Reset asserted mid-fetch: immediate return to reset values, no residual mem_en.
- instr_ready low in VALID: all outputs frozen, req_ready=0.

## Configuration
- IFETCH_ALIGN_CHECK_EN defined: misalign port present; request with req_addr[1:0]≠0 is accepted but issues no memory reads, goes IDLE/VALID → VALID in one edge with instr=32'h00000013 (NOP), misalign=1 while instr_valid; misalign clears on handshake or flush.
- Undefined: no misalign port; misaligned addresses fetched byte-wise as normal (wrap rules apply).

## Structure
- Package ifetch_pkg: state enum (IDLE, READ, LAST, VALID), BYTES_PER_INSTR=4, NOP_INSTR=32'h00000013.
- One natural sub-module: ifetch_assembler — byte-lane capture register with lane select and clear, producing instr.

## Test plan
- Reset: pulse rst_n low during READ k=2 → mem_en, instr_valid, instr drop to 0 immediately; req_ready=1 after release.
- Basic: ROM[0..3]=93,00,50,00, request addr 0 → mem_addr 0,1,2,3 cycles 1–4, instr_valid at cycle 6 with instr=0x00500093, instr_addr=0.
- Backpressure + back-to-back: hold instr_ready low 3 cycles → instr stable, req_ready=0; then raise with req_addr=4 → accepted same edge, next instr_valid 5 edges later.
- Truncation/wrap (macro off): req_addr=0x3E → mem_addr 1E,1F,00,01, instr_addr=0x3E.
- Flush: flush during READ k=2 with req_valid high → IDLE, req not accepted, instr_valid never asserts; following request fetches cleanly.
- Macro on: req_addr=0x2 → instr_valid next cycle, instr=0x00000013, misalign=1, mem_en never high.
